sevseg_display_scheduler: RTL and testbench

Shares the single 4-digit seven-segment display among NUM_SRC requesters, e.g. PC, ALU result, register readback and MMIO.
- Round-robin rotation with a fixed dwell time per source.
- Pin override for debug.
- Registered 16-bit value plus hex/BCD mode, fed straight into the display driver's DATA_IN/MODE inputs.

---
 rtl/sevseg_pkg.sv | 18 +
 rtl/sevseg_rr_pick.sv | 30 +++
 rtl/sevseg_display_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_sevseg_display_scheduler.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sevseg_pkg.sv
// Shared types, constants and helpers for the seven-segment display scheduler.
package sevseg_pkg;

    localparam int DATA_W = 16;
    localparam logic [DATA_W-1:0] BCD_MAX = 16'd9999;

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        PINNED
    } state_t;

    // Round-robin successor of an index, wrapping at the source count.
    function automatic int unsigned next_rr(input int unsigned idx, input int unsigned num);
        return (idx + 1) % num;
    endfunction

endpackage

// File: rtl/sevseg_rr_pick.sv
// Combinational rotate-priority picker: first set request at or after a start index, wrapping.
module sevseg_rr_pick #(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   start,
    output logic               found,
    output logic [NUM_SRC-1:0] onehot,
    output logic [IDX_W-1:0]   idx
);

    logic [31:0] pos;

    always_comb begin
        found  = 1'b0;
        onehot = '0;
        idx    = '0;
        pos    = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            pos = (32'(start) + 32'(k)) % 32'(NUM_SRC);
            if (!found && req[pos[IDX_W-1:0]]) begin
                found                = 1'b1;
                onehot[pos[IDX_W-1:0]] = 1'b1;
                idx                  = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/sevseg_display_scheduler.sv
// Round-robin owner of a shared 4-digit display with dwell timing and a debug pin override.
// Build option: define SEVSEG_SNAPSHOT_EN to freeze DATA_OUT/MODE_OUT at each grant.
module sevseg_display_scheduler
    import sevseg_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int DWELL_CYC = 50_000_000,
    parameter int IDX_W     = $clog2(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        req,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [NUM_SRC-1:0]        src_mode,
    input  logic                      pin_en,
    input  logic [IDX_W-1:0]          pin_sel,
    output logic [NUM_SRC-1:0]        grant,
    output logic [DATA_W-1:0]         data_out,
    output logic                      mode_out,
    output logic [IDX_W-1:0]          active_idx,
    output logic                      valid_out
);

    localparam int CNT_W = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYC - 1);

`ifdef SEVSEG_SNAPSHOT_EN
    localparam bit SNAPSHOT = 1'b1;
`else
    localparam bit SNAPSHOT = 1'b0;
`endif

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     rr_q, rr_d;
    logic [NUM_SRC-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 valid_q, valid_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic                 mode_q, mode_d;

    logic                 grant_evt;
    logic                 force_zero;
    logic                 pin_ok;
    logic [NUM_SRC-1:0]   pin_onehot;

    logic [IDX_W-1:0]     pick_start;
    logic                 pick_found;
    logic [NUM_SRC-1:0]   pick_onehot;
    logic [IDX_W-1:0]     pick_idx;

    logic [DATA_W-1:0]    sel_data;
    logic                 sel_mode;
    logic                 cap_mode;

    // While showing, the search starts just past the owner so a rotation never re-picks it first.
    assign pick_start = (state_q == SHOW) ? IDX_W'(next_rr(32'(idx_q), NUM_SRC)) : rr_q;

    sevseg_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req    (req),
        .start  (pick_start),
        .found  (pick_found),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    always_comb begin
        pin_ok     = (32'(pin_sel) < 32'(NUM_SRC));
        pin_onehot = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            pin_onehot[i] = (pin_sel == IDX_W'(i));
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rr_d       = rr_q;
        grant_d    = grant_q;
        idx_d      = idx_q;
        valid_d    = valid_q;
        grant_evt  = 1'b0;
        force_zero = 1'b0;

        if (pin_en) begin
            state_d    = PINNED;
            cnt_d      = '0;
            idx_d      = pin_sel;
            grant_d    = pin_onehot;
            valid_d    = pin_ok;
            force_zero = !pin_ok;
            grant_evt  = (state_q != PINNED) || (pin_sel != idx_q);
        end else begin
            case (state_q)
                SHOW: begin
                    if (!req[idx_q] || (cnt_q == CNT_LAST)) begin
                        if (pick_found) begin
                            cnt_d     = '0;
                            grant_d   = pick_onehot;
                            idx_d     = pick_idx;
                            valid_d   = 1'b1;
                            rr_d      = IDX_W'(next_rr(32'(pick_idx), NUM_SRC));
                            grant_evt = 1'b1;
                        end else begin
                            state_d = IDLE;
                            cnt_d   = '0;
                            grant_d = '0;
                            valid_d = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PINNED: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    grant_d = '0;
                    valid_d = 1'b0;
                    rr_d    = IDX_W'(next_rr(32'(pin_sel), NUM_SRC));
                end
                default: begin
                    if (pick_found) begin
                        state_d   = SHOW;
                        cnt_d     = '0;
                        grant_d   = pick_onehot;
                        idx_d     = pick_idx;
                        valid_d   = 1'b1;
                        rr_d      = IDX_W'(next_rr(32'(pick_idx), NUM_SRC));
                        grant_evt = 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        sel_data = '0;
        sel_mode = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (idx_d == IDX_W'(i)) begin
                sel_data = src_data[i*DATA_W +: DATA_W];
                sel_mode = src_mode[i];
            end
        end
        // The BCD path only spans four digits, so out-of-range values fall back to hex.
        cap_mode = sel_mode && (sel_data <= BCD_MAX);
    end

    // Going idle keeps the last value so the display never blanks between owners.
    always_comb begin
        data_d = data_q;
        mode_d = mode_q;
        if (force_zero) begin
            data_d = '0;
            mode_d = 1'b0;
        end else if (valid_d && (grant_evt || !SNAPSHOT)) begin
            data_d = sel_data;
            mode_d = cap_mode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rr_q    <= '0;
            grant_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
        end
    end

    assign grant      = grant_q;
    assign data_out   = data_q;
    assign mode_out   = mode_q;
    assign active_idx = idx_q;
    assign valid_out  = valid_q;

endmodule

// File: tb/tb_sevseg_display_scheduler.sv
// Self-checking bench for sevseg_display_scheduler with NUM_SRC=4, DWELL_CYC=4.
module tb_sevseg_display_scheduler;

    localparam int N  = 4;
    localparam int DW = 4;

`ifdef SEVSEG_SNAPSHOT_EN
    localparam bit SNAP = 1'b1;
`else
    localparam bit SNAP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [N*16-1:0] src_data;
    logic [N-1:0]  src_mode;
    logic          pin_en;
    logic [1:0]    pin_sel;
    logic [N-1:0]  grant;
    logic [15:0]   data_out;
    logic          mode_out;
    logic [1:0]    active_idx;
    logic          valid_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sevseg_display_scheduler #(
        .NUM_SRC   (N),
        .DWELL_CYC (DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .src_data   (src_data),
        .src_mode   (src_mode),
        .pin_en     (pin_en),
        .pin_sel    (pin_sel),
        .grant      (grant),
        .data_out   (data_out),
        .mode_out   (mode_out),
        .active_idx (active_idx),
        .valid_out  (valid_out)
    );

    // Behavioural model: who owns the display, for how long, and what it last showed.
    int          m_owner;
    bit          m_pinned;
    int          m_age;
    int          m_rr;
    int          m_idx;
    logic [15:0] m_data;
    bit          m_mode;

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] exp_grant;
        logic         exp_valid;
        logic [15:0]  exp_data;
    } vec_t;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] src_val(input int i);
        return src_data[16*i +: 16];
    endfunction

    task automatic set_src(input int i, input logic [15:0] v, input logic m);
        src_data[16*i +: 16] = v;
        src_mode[i]          = m;
    endtask

    function automatic int first_req(input int start);
        for (int k = 0; k < N; k++) begin
            if (req[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner  = -1;
        m_pinned = 0;
        m_age    = 0;
        m_rr     = 0;
        m_idx    = 0;
        m_data   = 16'h0000;
        m_mode   = 0;
    endtask

    task automatic model_step();
        bit fresh;
        int s;
        fresh = 0;
        if (pin_en) begin
            fresh    = !m_pinned || (int'(pin_sel) != m_idx);
            m_pinned = 1;
            m_age    = 0;
            m_idx    = int'(pin_sel);
            m_owner  = int'(pin_sel);
        end else if (m_pinned) begin
            m_pinned = 0;
            m_owner  = -1;
            m_rr     = (int'(pin_sel) + 1) % N;
        end else if (m_owner < 0) begin
            s = first_req(m_rr);
            if (s >= 0) begin
                m_owner = s; m_idx = s; m_age = 0; m_rr = (s + 1) % N; fresh = 1;
            end
        end else begin
            m_age++;
            if (!req[m_owner] || m_age == DW) begin
                s = first_req((m_owner + 1) % N);
                if (s >= 0) begin
                    m_owner = s; m_idx = s; m_age = 0; m_rr = (s + 1) % N; fresh = 1;
                end else begin
                    m_owner = -1;
                end
            end
        end
        if (m_owner >= 0 && (fresh || !SNAP)) begin
            m_data = src_val(m_owner);
            m_mode = src_mode[m_owner] && (m_data <= 16'd9999);
        end
    endtask

    task automatic model_check();
        logic [N-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        check_output("model_grant", 32'(grant), 32'(g));
        check_output("model_valid", 32'(valid_out), 32'(m_owner >= 0));
        check_output("model_data", 32'(data_out), 32'(m_data));
        check_output("model_mode", 32'(mode_out), 32'(m_mode));
        check_output("model_idx", 32'(active_idx), 32'(m_idx));
    endtask

    // One clock: the model sees the same inputs as the DUT at the edge, outputs sampled 1ns later.
    task automatic apply_stimulus();
        @(posedge clk);
        model_step();
        #1;
        model_check();
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        req     = '0;
        pin_en  = 1'b0;
        pin_sel = '0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    vec_t tbl[10];

    initial begin
        rst_n    = 1'b0;
        req      = '0;
        src_data = '0;
        src_mode = '0;
        pin_en   = 1'b0;
        pin_sel  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_grant", 32'(grant), 32'h0);
        check_output("reset_data", 32'(data_out), 32'h0);
        check_output("reset_mode", 32'(mode_out), 32'h0);
        check_output("reset_idx", 32'(active_idx), 32'h0);
        check_output("reset_valid", 32'(valid_out), 32'h0);
        rst_n = 1'b1;

        // Two-requester rotation, then owner drops with nobody left.
        tbl[0] = '{4'b1010, 4'b0010, 1'b1, 16'h1234};
        tbl[1] = '{4'b1010, 4'b0010, 1'b1, 16'h1234};
        tbl[2] = '{4'b1010, 4'b0010, 1'b1, 16'h1234};
        tbl[3] = '{4'b1010, 4'b0010, 1'b1, 16'h1234};
        tbl[4] = '{4'b1010, 4'b1000, 1'b1, 16'hBEEF};
        tbl[5] = '{4'b1010, 4'b1000, 1'b1, 16'hBEEF};
        tbl[6] = '{4'b1010, 4'b1000, 1'b1, 16'hBEEF};
        tbl[7] = '{4'b1010, 4'b1000, 1'b1, 16'hBEEF};
        tbl[8] = '{4'b1010, 4'b0010, 1'b1, 16'h1234};
        tbl[9] = '{4'b0000, 4'b0000, 1'b0, 16'h1234};
        set_src(1, 16'h1234, 1'b0);
        set_src(3, 16'hBEEF, 1'b0);
        for (int i = 0; i < 10; i++) begin
            req = tbl[i].req;
            apply_stimulus();
            check_output($sformatf("tbl%0d_grant", i), 32'(grant), 32'(tbl[i].exp_grant));
            check_output($sformatf("tbl%0d_valid", i), 32'(valid_out), 32'(tbl[i].exp_valid));
            check_output($sformatf("tbl%0d_data", i), 32'(data_out), 32'(tbl[i].exp_data));
        end

        // Lone requester is re-granted across dwell boundaries with no gap.
        do_reset();
        set_src(2, 16'h5A5A, 1'b0);
        req = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            apply_stimulus();
            check_output($sformatf("solo%0d_grant", i), 32'(grant), 32'h4);
        end

        // Owner drops mid-dwell: grant clears, data holds.
        do_reset();
        req = 4'b0100;
        apply_stimulus();
        apply_stimulus();
        req = 4'b0000;
        apply_stimulus();
        check_output("drop_grant", 32'(grant), 32'h0);
        check_output("drop_valid", 32'(valid_out), 32'h0);
        check_output("drop_data", 32'(data_out), 32'h5A5A);

        // Pin override beats arbitration; release resumes after the pinned index.
        do_reset();
        set_src(0, 16'h0A0A, 1'b0);
        req = 4'b0011;
        apply_stimulus();
        check_output("pin_pre_grant", 32'(grant), 32'h1);
        apply_stimulus();
        pin_en  = 1'b1;
        pin_sel = 2'd3;
        apply_stimulus();
        check_output("pin_grant", 32'(grant), 32'h8);
        check_output("pin_valid", 32'(valid_out), 32'h1);
        check_output("pin_data", 32'(data_out), 32'hBEEF);
        pin_en = 1'b0;
        apply_stimulus();
        check_output("unpin_grant", 32'(grant), 32'h0);
        check_output("unpin_valid", 32'(valid_out), 32'h0);
        apply_stimulus();
        check_output("unpin_wrap_grant", 32'(grant), 32'h1);

        // BCD range boundary.
        do_reset();
        set_src(2, 16'd9999, 1'b1);
        pin_en  = 1'b1;
        pin_sel = 2'd2;
        apply_stimulus();
        check_output("bcd9999_mode", 32'(mode_out), 32'h1);
        pin_en = 1'b0;
        apply_stimulus();
        set_src(2, 16'd10000, 1'b1);
        pin_en = 1'b1;
        apply_stimulus();
        check_output("bcd10000_mode", 32'(mode_out), 32'h0);
        check_output("bcd10000_data", 32'(data_out), 32'd10000);
        pin_en = 1'b0;

        // Asynchronous reset between edges, then arbitration restarts at index 0.
        do_reset();
        req = 4'b0100;
        apply_stimulus();
        apply_stimulus();
        req = 4'b1111;
        apply_stimulus();
        check_output("nopreempt_grant", 32'(grant), 32'h4);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_output("async_grant", 32'(grant), 32'h0);
        check_output("async_data", 32'(data_out), 32'h0);
        check_output("async_mode", 32'(mode_out), 32'h0);
        check_output("async_idx", 32'(active_idx), 32'h0);
        check_output("async_valid", 32'(valid_out), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply_stimulus();
        check_output("restart_grant", 32'(grant), 32'h1);

        // Owner data changes mid-dwell.
        do_reset();
        set_src(1, 16'h1111, 1'b0);
        req = 4'b0010;
        apply_stimulus();
        apply_stimulus();
        set_src(1, 16'h2222, 1'b0);
        apply_stimulus();
        check_output("middwell_data", 32'(data_out), SNAP ? 32'h1111 : 32'h2222);
        apply_stimulus();
        apply_stimulus();
        check_output("regrant_data", 32'(data_out), 32'h2222);

        // Randomised traffic against the model.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            req = N'($urandom);
            if ($urandom_range(0, 3) == 0) set_src($urandom_range(0, N-1), 16'($urandom), 1'($urandom));
            if (pin_en) begin
                if ($urandom_range(0, 7) == 0) pin_en = 1'b0;
            end else if ($urandom_range(0, 19) == 0) begin
                pin_en = 1'b1;
            end
            if ($urandom_range(0, 5) == 0) pin_sel = 2'($urandom);
            apply_stimulus();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
